// File: rtl/udma_filter_result_writer.sv
// udma_filter_result_writer: sink of the filter datapath. Accepts result
// samples, packs them little-endian into 32-bit words with byte enables and
// writes each word to L2 over a req/gnt port, pulsing done at the end.
module udma_filter_result_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cmd_start_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  l2_req_o,
    input  logic                  l2_gnt_i,
    output logic [ADDR_WIDTH-1:0] l2_addr_o,
    output logic [31:0]           l2_wdata_o,
    output logic [3:0]            l2_be_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [TRANS_SIZE-1:0] status_count_o
);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    state_t                state;
    logic [1:0]            datasize;
    logic [1:0]            lane;
    logic [TRANS_SIZE-1:0] remaining;

    logic [31:0] sample32;
    logic [31:0] lane_data;
    logic [3:0]  lane_be;
    logic [1:0]  lane_step;
    logic [1:0]  lane_next;
    logic [1:0]  start_lane;
    logic        word_full;
    logic        last_sample;

    // Place the current sample at its byte lane and work out the next lane
    always_comb begin
        sample32 = 32'(in_data_i);
        case (datasize)
            2'b00: begin
                lane_data = {24'h0, sample32[7:0]} << {lane, 3'b000};
                lane_be   = 4'b0001 << lane;
                lane_step = 2'd1;
            end
            2'b01: begin
                lane_data = {16'h0, sample32[15:0]} << {lane, 3'b000};
                lane_be   = 4'b0011 << lane;
                lane_step = 2'd2;
            end
            default: begin
                lane_data = sample32;
                lane_be   = 4'b1111;
                lane_step = 2'd0;
            end
        endcase
        lane_next   = lane + lane_step;
        word_full   = (lane_next == 2'd0);
        last_sample = (remaining == TRANS_SIZE'(1));
        case (cfg_datasize_i)
            2'b00:   start_lane = cfg_start_addr_i[1:0];
            2'b01:   start_lane = {cfg_start_addr_i[1], 1'b0};
            default: start_lane = 2'd0;
        endcase
    end

    // Transfer FSM; the L2 address/data/enable outputs double as the pack registers.
    // busy is raised on start and held through the cycle carrying the done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            datasize       <= '0;
            lane           <= '0;
            remaining      <= '0;
            in_ready_o     <= 1'b0;
            l2_req_o       <= 1'b0;
            l2_addr_o      <= '0;
            l2_wdata_o     <= '0;
            l2_be_o        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            status_count_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (cmd_start_i) begin
                        datasize       <= cfg_datasize_i;
                        remaining      <= cfg_size_i;
                        status_count_o <= '0;
                        l2_addr_o      <= {cfg_start_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        lane           <= start_lane;
                        l2_wdata_o     <= '0;
                        l2_be_o        <= '0;
                        busy_o         <= 1'b1;
                        if (cfg_size_i == '0) begin
                            state <= DONE;
                        end else begin
                            state      <= PACK;
                            in_ready_o <= 1'b1;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                PACK: begin
                    if (in_valid_i && in_ready_o) begin
                        l2_wdata_o     <= l2_wdata_o | lane_data;
                        l2_be_o        <= l2_be_o | lane_be;
                        lane           <= lane_next;
                        remaining      <= remaining - TRANS_SIZE'(1);
                        status_count_o <= status_count_o + TRANS_SIZE'(1);
                        if (word_full || last_sample) begin
                            in_ready_o <= 1'b0;
                            l2_req_o   <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (l2_gnt_i) begin
                        l2_req_o   <= 1'b0;
                        l2_addr_o  <= l2_addr_o + ADDR_WIDTH'(4);
                        l2_wdata_o <= '0;
                        l2_be_o    <= '0;
                        if (remaining == '0) begin
                            state <= DONE;
                        end else begin
                            state      <= PACK;
                            in_ready_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_filter_result_writer.sv
// Bench for udma_filter_result_writer: a byte-address model builds the list of
// expected L2 writes; one negedge process grants requests and checks each write.
module tb_udma_filter_result_writer;

    typedef struct {
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [17:0] cfg_start_addr_i = '0;
    logic [15:0] cfg_size_i = '0;
    logic [1:0]  cfg_datasize_i = '0;
    logic        cmd_start_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        l2_req_o;
    logic        l2_gnt_i = 1'b0;
    logic [17:0] l2_addr_o;
    logic [31:0] l2_wdata_o;
    logic [3:0]  l2_be_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] status_count_o;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned done_seen = 0;
    int unsigned d0 = 0;
    int unsigned gnt_delay = 0;
    int unsigned wait_cnt = 0;
    int unsigned stall_cycles = 0;

    wr_t         exp_q[$];
    bit          fill_q[$];
    logic [31:0] smp_q[$];

    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic [3:0]  prev_be = '0;

    udma_filter_result_writer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(18),
        .TRANS_SIZE(16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_start_addr_i(cfg_start_addr_i),
        .cfg_size_i      (cfg_size_i),
        .cfg_datasize_i  (cfg_datasize_i),
        .cmd_start_i     (cmd_start_i),
        .in_data_i       (in_data_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .l2_req_o        (l2_req_o),
        .l2_gnt_i        (l2_gnt_i),
        .l2_addr_o       (l2_addr_o),
        .l2_wdata_o      (l2_wdata_o),
        .l2_be_o         (l2_be_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .status_count_o  (status_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected writes: sample i lands at byte address start+i*size; each
    // distinct word touched becomes one write with only the touched bytes enabled.
    function automatic void build_model(input int unsigned start, input int unsigned size,
                                        input int unsigned ds);
        int unsigned nb;
        int unsigned a0;
        int unsigned ai;
        int unsigned wi;
        int unsigned cur_word;
        int unsigned ln;
        bit          open;
        wr_t         cur;
        nb = (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
        a0 = start & ~(nb - 1);
        open = 1'b0;
        cur_word = 0;
        cur.addr = '0;
        cur.wdata = '0;
        cur.be = '0;
        fill_q.delete();
        for (int unsigned i = 0; i < size; i++) begin
            ai = (a0 + i * nb) & 32'h3FFFF;
            wi = ai >> 2;
            if (open && wi != cur_word) begin
                exp_q.push_back(cur);
                open = 1'b0;
            end
            if (!open) begin
                cur.addr = 18'(wi * 4);
                cur.wdata = '0;
                cur.be = '0;
                cur_word = wi;
                open = 1'b1;
            end
            for (int unsigned k = 0; k < nb; k++) begin
                ln = (ai + k) % 4;
                cur.wdata[ln*8 +: 8] = 8'((smp_q[i] >> (8 * k)) & 32'hFF);
                cur.be[ln] = 1'b1;
            end
            fill_q.push_back(((ai + nb) % 4 == 0) || (i == size - 1));
        end
        if (open) exp_q.push_back(cur);
    endfunction

    // Grant driver and per-cycle write checker
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_req = 1'b0;
            prev_gnt = 1'b0;
            l2_gnt_i = 1'b0;
            wait_cnt = 0;
        end else begin
            if (done_o) done_seen++;
            if (prev_req && !prev_gnt) begin
                chk("req_held", l2_req_o, 1'b1);
                chk("write_stable", {l2_addr_o, l2_wdata_o, l2_be_o},
                    {prev_addr, prev_wdata, prev_be});
            end
            if (l2_req_o) begin
                chk("ready_low_in_write", in_ready_o, 1'b0);
                chk("busy_in_write", busy_o, 1'b1);
                if (wait_cnt >= gnt_delay) begin
                    l2_gnt_i = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got addr 0x%0h wdata 0x%0h be 0x%0h, required none",
                                 l2_addr_o, l2_wdata_o, l2_be_o);
                    end else begin
                        chk("l2_write", {l2_addr_o, l2_wdata_o, l2_be_o},
                            {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be});
                        void'(exp_q.pop_front());
                    end
                end else begin
                    l2_gnt_i = 1'b0;
                    wait_cnt++;
                    stall_cycles++;
                end
            end else begin
                l2_gnt_i = 1'b0;
                wait_cnt = 0;
            end
            prev_req = l2_req_o;
            prev_gnt = l2_gnt_i;
            prev_addr = l2_addr_o;
            prev_wdata = l2_wdata_o;
            prev_be = l2_be_o;
        end
    end

    task automatic pulse_start(input logic [17:0] addr, input logic [15:0] size, input logic [1:0] ds);
        @(negedge clk_i);
        cfg_start_addr_i = addr;
        cfg_size_i = size;
        cfg_datasize_i = ds;
        cmd_start_i = 1'b1;
        @(negedge clk_i);
        cmd_start_i = 1'b0;
    endtask

    task automatic send(input int unsigned from, input int unsigned to);
        int unsigned n;
        for (int unsigned i = from; i < to; i++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i = smp_q[i];
            n = 0;
            while (!in_ready_o && n < 200) begin
                @(negedge clk_i);
                n++;
            end
            chk("in_ready_wait", in_ready_o, 1'b1);
            if (!in_ready_o) begin
                in_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1 in_valid_i = 1'b0;
            if (fill_q[i]) begin
                @(negedge clk_i);
                chk("req_after_fill", l2_req_o, 1'b1);
            end
        end
    endtask

    task automatic finish_xfer(input logic [15:0] size);
        int unsigned n;
        n = 0;
        while (done_seen == d0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        chk("done_pulses", 64'(done_seen - d0), 64'd1);
        chk("writes_left", 64'(exp_q.size()), 64'd0);
        chk("status_count", status_count_o, size);
        chk("busy_after_done", busy_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("reset_ctl", {l2_req_o, in_ready_o, busy_o, done_o, l2_be_o}, '0);
        chk("reset_data", {l2_addr_o, l2_wdata_o}, '0);
        chk("reset_count", status_count_o, '0);
        rst_i = 1'b0;

        // Bytes, aligned, upper bits of some samples must be dropped
        smp_q = '{32'hFFFFFF11, 32'h00000022, 32'hABCDEF33, 32'h00000044, 32'h00000055, 32'h12345666};
        build_model(32'h100, 6, 0);
        chk("pin_t1_nwr", 64'(exp_q.size()), 64'd2);
        chk("pin_t1_w0", {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be}, {18'h100, 32'h44332211, 4'hF});
        chk("pin_t1_w1", {exp_q[1].addr, exp_q[1].wdata, exp_q[1].be}, {18'h104, 32'h00006655, 4'h3});
        gnt_delay = 0;
        d0 = done_seen;
        pulse_start(18'h100, 16'd6, 2'b00);
        chk("busy_after_start", busy_o, 1'b1);
        send(0, 6);
        finish_xfer(16'd6);

        // Halves, unaligned start
        smp_q = '{32'h1234AAAA, 32'h0000BBBB, 32'h0000CCCC};
        build_model(32'h202, 3, 1);
        chk("pin_t2_w0", {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be}, {18'h200, 32'hAAAA0000, 4'hC});
        chk("pin_t2_w1", {exp_q[1].addr, exp_q[1].wdata, exp_q[1].be}, {18'h204, 32'hCCCCBBBB, 4'hF});
        d0 = done_seen;
        pulse_start(18'h202, 16'd3, 2'b01);
        send(0, 3);
        finish_xfer(16'd3);

        // Words with a 5-cycle grant delay
        smp_q = '{32'h12345678, 32'h9ABCDEF0};
        build_model(32'h300, 2, 2);
        gnt_delay = 5;
        stall_cycles = 0;
        d0 = done_seen;
        pulse_start(18'h300, 16'd2, 2'b10);
        send(0, 2);
        finish_xfer(16'd2);
        chk("grant_stall_cycles", 64'(stall_cycles), 64'd10);
        gnt_delay = 0;

        // Zero size
        d0 = done_seen;
        pulse_start(18'h400, 16'd0, 2'b00);
        chk("zero_c1", {busy_o, done_o, l2_req_o}, 3'b100);
        @(negedge clk_i);
        chk("zero_c2", {busy_o, done_o, l2_req_o}, 3'b110);
        @(negedge clk_i);
        chk("zero_c3", {busy_o, done_o, l2_req_o}, 3'b000);
        chk("zero_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("zero_count", status_count_o, 16'd0);

        // Address wrap, datasize 11 treated as word
        smp_q = '{32'hCAFEF00D, 32'h0BADBEEF};
        build_model(32'h3FFFC, 2, 3);
        chk("pin_t5_w0", {exp_q[0].addr, exp_q[0].be}, {18'h3FFFC, 4'hF});
        chk("pin_t5_w1", {exp_q[1].addr, exp_q[1].wdata}, {18'h00000, 32'h0BADBEEF});
        d0 = done_seen;
        pulse_start(18'h3FFFC, 16'd2, 2'b11);
        send(0, 2);
        finish_xfer(16'd2);

        // Start ignored mid-transfer; unaligned bytes fill a partial word
        smp_q = '{32'h000000A1, 32'h000000B2, 32'h000000C3};
        build_model(32'h601, 3, 0);
        chk("pin_t6_w0", {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be}, {18'h600, 32'hC3B2A100, 4'hE});
        d0 = done_seen;
        pulse_start(18'h601, 16'd3, 2'b00);
        send(0, 1);
        pulse_start(18'h000, 16'd1, 2'b10);
        send(1, 3);
        finish_xfer(16'd3);

        // Valid while idle is not accepted and the count holds
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_data_i = 32'h77;
        repeat (6) @(negedge clk_i);
        chk("idle_ready_low", in_ready_o, 1'b0);
        in_valid_i = 1'b0;
        chk("idle_count_hold", status_count_o, 16'd3);
        chk("idle_no_writes", 64'(exp_q.size()), 64'd0);

        // Reset while a write is pending
        smp_q = '{32'h11112222, 32'h33334444};
        build_model(32'h500, 2, 2);
        gnt_delay = 1000;
        pulse_start(18'h500, 16'd2, 2'b10);
        send(0, 1);
        repeat (3) @(negedge clk_i);
        chk("req_pending", {l2_req_o, l2_addr_o}, {1'b1, 18'h500});
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_ctl", {l2_req_o, in_ready_o, busy_o, done_o, l2_be_o}, '0);
        chk("async_rst_data", {l2_addr_o, l2_wdata_o, status_count_o}, '0);
        exp_q.delete();
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        gnt_delay = 0;

        // Restart after reset
        smp_q = '{32'hFFFFFF5A};
        build_model(32'h40, 1, 0);
        chk("pin_t7_w0", {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be}, {18'h040, 32'h0000005A, 4'h1});
        d0 = done_seen;
        pulse_start(18'h040, 16'd1, 2'b00);
        send(0, 1);
        finish_xfer(16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
